// File: rtl/dec_pkg.sv
// Shared decoder definitions: decoded word width, codeword width and the
// buffered entry layout used by the encoder, decoder and output buffer.
package dec_pkg;

    localparam int DATA_W = 6;
    localparam int CW_W   = 19;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              corr;
    } dec_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO of decoder entries; occupancy is tracked
// separately from the wrapping pointers so full and empty are unambiguous.
module sync_fifo
    import dec_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [DATA_W:0] wr_word,
    output logic            full,
    output logic            empty,
    output logic [DATA_W:0] rd_word
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DATA_W:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [OW-1:0]   occ;

    assign full  = (occ == OW'(DEPTH));
    assign empty = (occ == '0);

    // Storage is never reset; the head is forced to zero whenever nothing is queued.
    assign rd_word = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                occ <= occ + OW'(1);
            end else if (pop && !push) begin
                occ <= occ - OW'(1);
            end
        end
    end

endmodule

// File: rtl/dec_out_buffer.sv
// Output buffer behind decoder stage 3: FIFO with sticky overflow flag and,
// when ERR_CNT_EN is defined, a saturating corrected-error counter.
module dec_out_buffer
    import dec_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_corr,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corr,
    input  logic              out_ready,
`ifdef ERR_CNT_EN
    output logic [CNT_W-1:0]  err_count,
`endif
    output logic              overflow
);

    dec_entry_t in_entry;
    dec_entry_t head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;

    assign in_entry = '{data: in_data, corr: in_corr};
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready && !reset;
    assign pop       = out_valid && out_ready && !reset;
    assign out_data  = head.data;
    assign out_corr  = head.corr;

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_word (in_entry),
        .full    (full),
        .empty   (empty),
        .rd_word (head)
    );

    // The decoder cannot stall, so a word offered while full is lost for good.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end
    end

`ifdef ERR_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (push && in_corr) begin
            err_count <= sat_inc(err_count);
        end
    end
`endif

endmodule

// File: tb/tb_dec_out_buffer.sv
// Directed bench for dec_out_buffer (DEPTH=4, CNT_W=2); counter checks run
// only when ERR_CNT_EN is defined.
module tb_dec_out_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [5:0] in_data;
    logic       in_corr;
    logic       in_ready;
    logic       out_valid;
    logic [5:0] out_data;
    logic       out_corr;
    logic       out_ready;
    logic       overflow;
`ifdef ERR_CNT_EN
    logic [1:0] err_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec_out_buffer #(
        .DEPTH (4),
        .CNT_W (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_corr   (in_corr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_corr  (out_corr),
        .out_ready (out_ready),
`ifdef ERR_CNT_EN
        .err_count (err_count),
`endif
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [5:0] d, input logic c);
        in_valid = 1'b1;
        in_data  = d;
        in_corr  = c;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_corr   = 1'b0;
        out_ready = 1'b0;

        // Reset held two cycles, then released
        step();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_corr", out_corr, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;
        step();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
`ifdef ERR_CNT_EN
        chk("rst_err_count", err_count, 0);
`endif

        // Single word, stalled consumer, then one pop
        push_word(6'h2A, 1'b0);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 6'h2A);
        chk("single_corr", out_corr, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 6'h2A);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_popped", out_valid, 0);

        // Fill to full, fifth word overflows
        for (int i = 1; i <= 4; i++) begin
            push_word(6'(i), 1'b0);
            chk("fill_head", out_data, 1);
        end
        chk("full_in_ready", in_ready, 0);
        chk("full_no_ovf_yet", overflow, 0);
        push_word(6'd5, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, i);
            step();
        end
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 0);
        chk("ovf_sticky", overflow, 1);

        // Two queued, then simultaneous push/pop for 8 cycles
        push_word(6'd10, 1'b0);
        push_word(6'd11, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("pp_head", out_data, 10 + k);
            in_valid  = 1'b1;
            in_data   = 6'(12 + k);
            in_corr   = 1'b0;
            out_ready = 1'b1;
            step();
            chk("pp_in_ready", in_ready, 1);
            chk("pp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        chk("pp_tail0", out_data, 18);
        step();
        chk("pp_tail1", out_data, 19);
        step();
        out_ready = 1'b0;
        chk("pp_occ2_empty", out_valid, 0);

        // Corrected word dropped while full is not counted
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_overflow", overflow, 0);
        for (int i = 0; i < 4; i++) push_word(6'(32 + i), 1'b0);
        push_word(6'h3F, 1'b1);
        chk("drop_ovf", overflow, 1);
`ifdef ERR_CNT_EN
        chk("drop_no_count", err_count, 0);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drop_drain", out_data, 32 + i);
            step();
        end

        // Five corrected words with consumer ready: counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            push_word(6'(40 + i), 1'b1);
            chk("corr_head", out_data, 40 + i);
            chk("corr_flag", out_corr, 1);
`ifdef ERR_CNT_EN
            chk("err_count", err_count, (i < 3) ? i + 1 : 3);
`endif
        end
        step();
        out_ready = 1'b0;
        chk("corr_empty", out_valid, 0);

        // Reset mid-operation with 3 entries queued and overflow set
        for (int i = 0; i < 4; i++) push_word(6'(50 + i), 1'b0);
        push_word(6'h3E, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_ovf", overflow, 1);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 6'h3F;
        in_corr  = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_ovf", overflow, 0);
`ifdef ERR_CNT_EN
        chk("mid_rst_count", err_count, 0);
`endif
        push_word(6'h15, 1'b0);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 6'h15);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_rst_empty", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_out_buffer.md
# dec_out_buffer

Output buffer that sits directly downstream of the pipelined decoder's third register stage. It captures each decoded 6-bit word and its "bit corrected" flag, and holds them in a small FIFO. Words leave through a valid/ready handshake toward the consumer. The decoder pipeline cannot stall, so the block also flags dropped words and counts corrected errors for the bench.

## Interface
- DATA_W, 6, decoded data width (matches decoder output q)
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 16, width of corrected-error counter
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decoder stage-3 word valid this cycle
- in_data  in  DATA_W  decoded word
- in_corr  in  1  decoder corrected a single-bit error in this word (nonzero syndrome)
- in_ready  out  1  FIFO can accept a word (not full)
- out_valid  out  1  head entry present
- out_data  out  DATA_W  head entry data
- out_corr  out  1  head entry corrected flag
- out_ready  in  1  consumer accepts head this cycle
- overflow  out  1  sticky: a word arrived while full and was dropped
- err_count  out  CNT_W  saturating count of accepted words with in_corr=1 (ERR_CNT_EN only)

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Occupancy counter 0..DEPTH; full = (occ==DEPTH), empty = (occ==0); in_ready = !full; out_valid = !empty.
- Write pointer and read pointer are log2(DEPTH) bits and wrap modulo DEPTH; occupancy is held separately to disambiguate full and empty.
- Push only: occ+1. Pop only: occ-1. Push and pop together: occ unchanged, both pointers advance. This is legal at any occupancy where in_ready=1.
- No bypass: a push into an empty FIFO becomes visible on out_valid one cycle later.
- in_valid while full: the word is discarded, overflow is set, and FIFO contents are untouched. overflow clears only on reset.
- out_data/out_corr are driven from the head entry (show-ahead). They are held stable while out_valid & !out_ready.
- err_count increments on a push with in_corr=1 and saturates at 2^CNT_W−1. Dropped words are not counted.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_corr=0, overflow=0, err_count=0, occ=0, pointers=0. Memory contents are don't-care.
- Reset asserted mid-operation flushes all entries on that edge. Words presented during reset are ignored.
- Latency from in_valid to out_valid is 1 cycle when the FIFO is empty.
- Throughput is 1 word/cycle when out_ready is held high.
- in_ready depends only on registered state, with no combinational path from out_ready.

## Configuration
- ERR_CNT_EN defined: the err_count port and its saturating counter are present.
- ERR_CNT_EN undefined: the err_count port is absent and in_corr is only stored and forwarded. The FIFO behaviour is otherwise identical.

## Structure
- Shared package dec_pkg holds DATA_W (6), the codeword width (19), and the typedef of the FIFO entry struct {data, corr}. The encoder, decoder and this block all import it.
- One sub-module, sync_fifo, holds the pointers, occupancy and storage. dec_out_buffer adds the overflow flag and error counter around it.

## Test plan
- Reset held 2 cycles, then released: in_ready=1, out_valid=0, overflow=0, err_count=0.
- Push 6'h2A with corr=0, out_ready=0: out_valid=1 next cycle, out_data=6'h2A. Data stays stable for 3 stalled cycles, then one cycle of out_ready=1 pops it and out_valid drops.
- With out_ready=0, push 5 words 1..5 at DEPTH=4: after the 4th push in_ready=0, the 5th sets overflow=1. Draining yields 1,2,3,4, and overflow stays 1.
- Fill 2 entries, then push and pop together for 8 cycles: occupancy stays 2, output order is preserved, and the pointers wrap twice.
- ERR_CNT_EN with CNT_W=2: push 5 words with corr=1 → err_count reads 1,2,3,3,3. A dropped corrected word while full does not increment it.
- Reset asserted with 3 entries queued: next cycle out_valid=0, in_ready=1, overflow=0. The next pushed word 6'h15 is the first word out.
